// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns single-cycle register read/write requests into
// START / DATA / READ / STOP command sequences for a byte-level I2C master.
// Every phase runs ISSUE (one strobe cycle), WAIT_HI (master busy) and
// WAIT_LO (master idle again). A NACK on a data byte jumps straight to STOP.
// Optional build macro I2C_SEQ_TIMEOUT_EN adds a per-phase watchdog of
// TIMEOUT_CYCLES wait cycles that abandons the sequence without STOP.
module i2c_reg_sequencer #(
  parameter int ADDRESS_BITS   = 7,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [ADDRESS_BITS-1:0] devAddr,
  input  logic [7:0]              regAddr,
  input  logic [7:0]              wrData,
  input  logic                    reqWrite,
  input  logic                    reqRead,
  output logic                    reqReady,
  output logic [7:0]              rdData,
  output logic                    rdValid,
  output logic                    nackErr,
  output logic                    mStart,
  output logic                    mStop,
  output logic                    mGo,
  output logic                    mReadNWrite,
  output logic [9:0]              mDIn,
  output logic                    mSendAck,
  input  logic                    mBusy,
  input  logic                    mRecvAck,
  input  logic [7:0]              mDOut
);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START_W,
    PH_REG,
    PH_WDATA,
    PH_START_R,
    PH_READ,
    PH_STOP
  } phase_t;

  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_WAIT_HI,
    SUB_WAIT_LO
  } sub_t;

  phase_t      phase_q;
  sub_t        sub_q;
  logic        is_read_q;
  logic [9:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdat_q;
  logic        reqReady_q;
  logic [7:0]  rdData_q;
  logic        rdValid_q;
  logic        nackErr_q;
  logic        mStart_q;
  logic        mStop_q;
  logic        mGo_q;
  logic        mReadNWrite_q;
  logic [9:0]  mDIn_q;
  logic        mSendAck_q;

  logic [9:0]  dev_in_ext;
  logic        req_accept;
  logic        phase_done;
  logic        data_nack;
  logic        launch_en;
  logic        tmo_hit;
  phase_t      next_phase_d;
  logic        launch_start_d;
  logic        launch_go_d;
  logic        launch_stop_d;
  logic        launch_rnw_d;
  logic [9:0]  launch_din_d;

  // Zero-extend the device address to the 10-bit master data bus
  always_comb begin
    dev_in_ext                     = '0;
    dev_in_ext[ADDRESS_BITS-1:0]   = devAddr;
  end

  assign req_accept = (phase_q == PH_IDLE) && (reqWrite || reqRead);
  assign phase_done = (phase_q != PH_IDLE) && (sub_q == SUB_WAIT_LO) && !mBusy;
  assign data_nack  = phase_done && mRecvAck &&
                      ((phase_q == PH_REG) || (phase_q == PH_WDATA));
  assign launch_en  = req_accept || (phase_done && (phase_q != PH_STOP));

  // Phase that follows the current one; a data NACK short-cuts to STOP
  always_comb begin
    next_phase_d = PH_IDLE;
    case (phase_q)
      PH_IDLE:    next_phase_d = PH_START_W;
      PH_START_W: next_phase_d = PH_REG;
      PH_REG:     next_phase_d = data_nack ? PH_STOP :
                                 (is_read_q ? PH_START_R : PH_WDATA);
      PH_WDATA:   next_phase_d = PH_STOP;
      PH_START_R: next_phase_d = PH_READ;
      PH_READ:    next_phase_d = PH_STOP;
      default:    next_phase_d = PH_IDLE;
    endcase
  end

  // Strobe and data-bus values presented during the ISSUE of the next phase
  always_comb begin
    launch_start_d = 1'b0;
    launch_go_d    = 1'b0;
    launch_stop_d  = 1'b0;
    launch_rnw_d   = mReadNWrite_q;
    launch_din_d   = mDIn_q;
    case (next_phase_d)
      PH_START_W: begin
        launch_start_d = 1'b1;
        launch_rnw_d   = 1'b0;
        launch_din_d   = dev_in_ext;  // launched only from IDLE: live inputs
      end
      PH_REG: begin
        launch_go_d  = 1'b1;
        launch_rnw_d = 1'b0;
        launch_din_d = {2'b00, reg_q};
      end
      PH_WDATA: begin
        launch_go_d  = 1'b1;
        launch_rnw_d = 1'b0;
        launch_din_d = {2'b00, wdat_q};
      end
      PH_START_R: begin
        launch_start_d = 1'b1;
        launch_rnw_d   = 1'b1;
        launch_din_d   = dev_q;
      end
      PH_READ: begin
        launch_go_d  = 1'b1;
        launch_rnw_d = 1'b1;
      end
      PH_STOP: launch_stop_d = 1'b1;
      default: ;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Watchdog: cleared in ISSUE (and IDLE), counts every wait cycle
  always_ff @(posedge clk) begin
    if (!resetN) begin
      tmo_cnt_q <= '0;
    end else if ((phase_q == PH_IDLE) || (sub_q == SUB_ISSUE)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Fires on the edge where the count reaches TIMEOUT_CYCLES without progress
  assign tmo_hit = (phase_q != PH_IDLE) && (sub_q != SUB_ISSUE) && !phase_done &&
                   (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built in
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Sequencer state machine with registered strobes and status outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      phase_q       <= PH_IDLE;
      sub_q         <= SUB_ISSUE;
      is_read_q     <= 1'b0;
      dev_q         <= '0;
      reg_q         <= '0;
      wdat_q        <= '0;
      reqReady_q    <= 1'b1;
      rdData_q      <= '0;
      rdValid_q     <= 1'b0;
      nackErr_q     <= 1'b0;
      mStart_q      <= 1'b0;
      mStop_q       <= 1'b0;
      mGo_q         <= 1'b0;
      mReadNWrite_q <= 1'b0;
      mDIn_q        <= '0;
      mSendAck_q    <= 1'b0;
    end else begin
      mStart_q  <= 1'b0;
      mStop_q   <= 1'b0;
      mGo_q     <= 1'b0;
      rdValid_q <= 1'b0;
      nackErr_q <= 1'b0;

      if (phase_q != PH_IDLE) begin
        case (sub_q)
          SUB_ISSUE:   sub_q <= SUB_WAIT_HI;
          SUB_WAIT_HI: if (mBusy) sub_q <= SUB_WAIT_LO;
          SUB_WAIT_LO: ;
          default:     sub_q <= SUB_ISSUE;
        endcase
      end

      if (phase_done) begin
        if (phase_q == PH_READ) begin
          rdData_q  <= mDOut;
          rdValid_q <= 1'b1;
        end
        if (data_nack) nackErr_q <= 1'b1;
        if (phase_q == PH_STOP) begin
          phase_q    <= PH_IDLE;
          sub_q      <= SUB_ISSUE;
          reqReady_q <= 1'b1;
        end
      end

      if (req_accept) begin
        dev_q      <= dev_in_ext;
        reg_q      <= regAddr;
        wdat_q     <= wrData;
        is_read_q  <= ~reqWrite;  // write wins when both pulse together
        reqReady_q <= 1'b0;
      end

      if (launch_en) begin
        phase_q       <= next_phase_d;
        sub_q         <= SUB_ISSUE;
        mStart_q      <= launch_start_d;
        mGo_q         <= launch_go_d;
        mStop_q       <= launch_stop_d;
        mReadNWrite_q <= launch_rnw_d;
        mDIn_q        <= launch_din_d;
        mSendAck_q    <= 1'b0;  // single-byte reads always ACK
      end

      if (tmo_hit) begin
        nackErr_q  <= 1'b1;
        phase_q    <= PH_IDLE;
        sub_q      <= SUB_ISSUE;
        reqReady_q <= 1'b1;
      end
    end
  end

  assign reqReady    = reqReady_q;
  assign rdData      = rdData_q;
  assign rdValid     = rdValid_q;
  assign nackErr     = nackErr_q;
  assign mStart      = mStart_q;
  assign mStop       = mStop_q;
  assign mGo         = mGo_q;
  assign mReadNWrite = mReadNWrite_q;
  assign mDIn        = mDIn_q;
  assign mSendAck    = mSendAck_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: directed requests push expected
// master commands / status pulses into a queue; a negedge monitor pops and
// compares each one as the sequencer produces it. A small master model
// answers strobes with a short busy pulse, optional NACK and read data.
module tb_i2c_reg_sequencer;
  localparam int AB = 7;
  localparam logic [3:0] EV_NACK  = 4'd1;
  localparam logic [3:0] EV_RD    = 4'd2;
  localparam logic [3:0] EV_START = 4'd3;
  localparam logic [3:0] EV_DATA  = 4'd4;
  localparam logic [3:0] EV_READ  = 4'd5;
  localparam logic [3:0] EV_STOP  = 4'd6;

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          resetN;
  logic [AB-1:0] devAddr;
  logic [7:0]    regAddr;
  logic [7:0]    wrData;
  logic          reqWrite;
  logic          reqRead;
  logic          reqReady;
  logic [7:0]    rdData;
  logic          rdValid;
  logic          nackErr;
  logic          mStart;
  logic          mStop;
  logic          mGo;
  logic          mReadNWrite;
  logic [9:0]    mDIn;
  logic          mSendAck;
  logic          mBusy = 1'b0;
  logic          mRecvAck = 1'b0;
  logic [7:0]    mDOut = 8'h00;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.ADDRESS_BITS(AB), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetN(resetN), .devAddr(devAddr), .regAddr(regAddr),
    .wrData(wrData), .reqWrite(reqWrite), .reqRead(reqRead),
    .reqReady(reqReady), .rdData(rdData), .rdValid(rdValid), .nackErr(nackErr),
    .mStart(mStart), .mStop(mStop), .mGo(mGo), .mReadNWrite(mReadNWrite),
    .mDIn(mDIn), .mSendAck(mSendAck), .mBusy(mBusy), .mRecvAck(mRecvAck),
    .mDOut(mDOut)
  );

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         nack_idx = -1;
  logic [7:0] read_val = 8'h00;
  bit         stall = 1'b0;
  int         cmd_cnt = 0;
  int         busy_left = 0;

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic expect_ev(input logic [3:0] k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string name, input logic [3:0] k, input logic [15:0] v);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got unexpected event value %h, expected no event", name, v);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind !== k) || (e.val !== v)) begin
        miscompares++;
        $display("FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                 name, k, v, e.kind, e.val);
      end else begin
        $display("ok   event %s value %h", name, v);
      end
    end
  endtask

  // Master model: busy for three cycles after each strobe
  always @(negedge clk) begin
    if (resetN !== 1'b1) begin
      mBusy     = 1'b0;
      busy_left = 0;
      mRecvAck  = 1'b0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) mBusy = 1'b0;
      end
      if (mStart || mGo || mStop) begin
        cmd_cnt++;
        if (!stall) begin
          mBusy     = 1'b1;
          busy_left = 3;
          mRecvAck  = (cmd_cnt == nack_idx);
          mDOut     = read_val;
        end
      end
    end
  end

  // Monitor: completion pulses first, then the strobe launched that cycle
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (nackErr) observe("nackErr", EV_NACK, 16'h0);
      if (rdValid) observe("rdValid", EV_RD, {8'h00, rdData});
      if (mStart)  observe("mStart", EV_START, {5'b0, mReadNWrite, mDIn});
      if (mGo && !mReadNWrite) observe("mGo_data", EV_DATA, {6'b0, mDIn});
      if (mGo && mReadNWrite)  observe("mGo_read", EV_READ, {14'b0, mReadNWrite, mSendAck});
      if (mStop)   observe("mStop", EV_STOP, 16'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input bit w, input bit r, input logic [AB-1:0] dev,
                        input logic [7:0] ra, input logic [7:0] wd);
    devAddr  = dev;
    regAddr  = ra;
    wrData   = wd;
    reqWrite = w;
    reqRead  = r;
    tick();
    reqWrite = 1'b0;
    reqRead  = 1'b0;
    devAddr  = ~dev;   // inputs must have been captured on accept
    regAddr  = ~ra;
    wrData   = ~wd;
    check_val("req_to_mstart_latency", {15'b0, mStart}, 16'h1);
    check_val("reqready_low_busy", {15'b0, reqReady}, 16'h0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!((reqReady === 1'b1) && (mBusy === 1'b0)) && (n < 300)) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s_idle: got busy after 300 cycles, expected return to idle", name);
    end
    repeat (6) tick();
    check_val({name, "_queue_drained"}, 16'(exp_q.size()), 16'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_reqReady"},    {15'b0, reqReady},    16'h1);
    check_val({tag, "_rdData"},      {8'b0, rdData},       16'h0);
    check_val({tag, "_rdValid"},     {15'b0, rdValid},     16'h0);
    check_val({tag, "_nackErr"},     {15'b0, nackErr},     16'h0);
    check_val({tag, "_mStart"},      {15'b0, mStart},      16'h0);
    check_val({tag, "_mStop"},       {15'b0, mStop},       16'h0);
    check_val({tag, "_mGo"},         {15'b0, mGo},         16'h0);
    check_val({tag, "_mReadNWrite"}, {15'b0, mReadNWrite}, 16'h0);
    check_val({tag, "_mDIn"},        {6'b0, mDIn},         16'h0);
    check_val({tag, "_mSendAck"},    {15'b0, mSendAck},    16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    int n;
    resetN   = 1'b0;
    reqWrite = 1'b0;
    reqRead  = 1'b0;
    devAddr  = '0;
    regAddr  = 8'h00;
    wrData   = 8'h00;
    repeat (3) tick();
    check_reset_values("reset");
    resetN = 1'b1;
    tick();
    check_val("reqready_after_release", {15'b0, reqReady}, 16'h1);

    // Plain write, all bytes ACKed
    expect_ev(EV_START, 16'h0050);
    expect_ev(EV_DATA,  16'h0010);
    expect_ev(EV_DATA,  16'h00A5);
    expect_ev(EV_STOP,  16'h0000);
    do_req(1'b1, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle("write");

    // Register read with repeated START
    read_val = 8'h71;
    expect_ev(EV_START, 16'h0068);
    expect_ev(EV_DATA,  16'h0075);
    expect_ev(EV_START, 16'h0468);
    expect_ev(EV_READ,  16'h0002);
    expect_ev(EV_RD,    16'h0071);
    expect_ev(EV_STOP,  16'h0000);
    do_req(1'b0, 1'b1, 7'h68, 8'h75, 8'h00);
    wait_idle("read");
    check_val("rddata_hold_after_read", {8'b0, rdData}, 16'h0071);

    // NACK on the register byte: no payload phase, straight to STOP
    nack_idx = cmd_cnt + 2;
    expect_ev(EV_START, 16'h003C);
    expect_ev(EV_DATA,  16'h0022);
    expect_ev(EV_NACK,  16'h0000);
    expect_ev(EV_STOP,  16'h0000);
    do_req(1'b1, 1'b0, 7'h3C, 8'h22, 8'h99);
    wait_idle("nack");
    nack_idx = -1;
    check_val("rddata_hold_after_nack", {8'b0, rdData}, 16'h0071);

    // Simultaneous write+read, then a read pulse mid-sequence: write only
    read_val = 8'hEE;
    expect_ev(EV_START, 16'h0011);
    expect_ev(EV_DATA,  16'h0033);
    expect_ev(EV_DATA,  16'h005A);
    expect_ev(EV_STOP,  16'h0000);
    do_req(1'b1, 1'b1, 7'h11, 8'h33, 8'h5A);
    repeat (3) tick();
    reqRead = 1'b1;
    tick();
    reqRead = 1'b0;
    wait_idle("contention");
    check_val("rddata_hold_after_contention", {8'b0, rdData}, 16'h0071);

    // Reset during WAIT_LO of the register-address phase of a read
    read_val = 8'h71;
    base = cmd_cnt;
    expect_ev(EV_START, 16'h0068);
    expect_ev(EV_DATA,  16'h0075);
    do_req(1'b0, 1'b1, 7'h68, 8'h75, 8'h00);
    n = 0;
    while ((cmd_cnt < base + 2) && (n < 100)) begin
      tick();
      n++;
    end
    check_val("reset_test_reached_reg_phase", 16'(cmd_cnt - base), 16'h2);
    tick();
    tick();
    resetN = 1'b0;
    tick();
    check_reset_values("midreset");
    resetN = 1'b1;
    tick();
    check_val("reqready_after_midreset", {15'b0, reqReady}, 16'h1);
    repeat (10) tick();
    check_val("midreset_queue_drained", 16'(exp_q.size()), 16'h0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never goes busy: watchdog abandons the sequence without STOP
    stall = 1'b1;
    expect_ev(EV_START, 16'h002A);
    expect_ev(EV_NACK,  16'h0000);
    do_req(1'b1, 1'b0, 7'h2A, 8'h01, 8'h02);
    n = 0;
    while ((nackErr !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    check_val("timeout_latency", 16'(n), 16'd17);
    wait_idle("timeout");
    stall = 1'b0;
`endif

    check_val("final_queue_empty", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
